line_buffer_initiator: RTL and testbench
========================================

# line_buffer_initiator

Single-line buffer and memory initiator between a 32-bit word-access CPU port and the 256-bit line-granular physical memory port. It holds one 32-byte line with its tag, valid and dirty bits and serves word reads/writes from that line. On a miss it issues line write-backs and line fills toward the dual-port line memory, acting as the requester for one of that memory's ports.

## Interface
Parameters: none (widths fixed by `line_buf_pkg`).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU word read request, held until mem_resp
- mem_write  in  1  CPU word write request, held until mem_resp
- mem_byte_enable  in  4  byte mask for writes; bit i covers wdata[8i+7:8i]
- mem_address  in  32  byte address; [1:0] ignored
- mem_wdata  in  32  write word
- mem_resp  out  1  request completes this cycle
- mem_rdata  out  32  read word, valid when mem_resp is high
- pmem_read  out  1  line read request, held until pmem_resp
- pmem_write  out  1  line write request, held until pmem_resp
- pmem_address  out  32  line address, [4:0] always 0
- pmem_wdata  out  256  line write data
- pmem_resp  in  1  memory completion; may be high in the same cycle as the request
- pmem_rdata  in  256  fill data, sampled on the edge where pmem_resp is high

## Operation
- Fields: tag = mem_address[31:5], word index = mem_address[4:2], line word w = line[32w+31:32w].
- Hit = valid && (stored tag == mem_address[31:5]).
- States: IDLE, WRITEBACK, FILL (plus WTHRU, see Configuration).
- IDLE:
  - Read hit: mem_resp=1, mem_rdata = line word at index.
  - Write hit: mem_resp=1; at the edge, merge enabled bytes into the word and set dirty.
  - Miss, dirty: go to WRITEBACK. Miss, clean or invalid: go to FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={stored tag,5'b0}, pmem_wdata=line.
  - On pmem_resp: clear dirty, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={mem_address[31:5],5'b0}.
  - On pmem_resp: load pmem_rdata, load tag, valid=1, dirty=0, go to IDLE.
  - The pending request then hits in IDLE.
- mem_read and mem_write both high: treated as a write.
- pmem_read and pmem_write are never high together.
- mem_resp is never high outside IDLE.
- mem_rdata is driven from the buffer continuously. It is meaningful only with mem_resp.

## Timing
- Hit: mem_resp in the request cycle (0 wait states).
- Clean miss with a zero-wait responder:
  - Cycle 0: IDLE, miss.
  - Cycle 1: FILL, pmem_resp=1.
  - Cycle 2: IDLE, hit, mem_resp.
- Dirty miss adds one WRITEBACK cycle per responder latency.
- Responder latency N cycles: a state holds its strobe for N cycles and advances on the edge where pmem_resp is high.
- CPU must hold address, data and strobes stable until mem_resp. A changed address mid-FILL is not supported.
- Reset (async, any state):
  - state=IDLE, valid=0, dirty=0, tag=0, line=0 immediately.
  - Outputs during reset: mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - An aborted FILL/WRITEBACK is dropped without retry.
- Nothing completes in the same cycle as rst high.

## Configuration
- `LINE_BUF_WRITE_THROUGH_EN` defined:
  - Dirty bit and WRITEBACK state are removed.
  - Write hit merges the word at the edge, then enters WTHRU: pmem_write=1 with the updated line at {tag,5'b0}.
  - mem_resp=1 in the WTHRU cycle where pmem_resp=1, then back to IDLE.
  - Write latency with a zero-wait responder: 1 cycle on hit; 3 cycles on miss (FILL, IDLE merge, WTHRU).
  - Read behaviour is unchanged.
- Undefined: write-back behaviour as in Operation.

## Structure
- `line_buf_pkg`:
  - line_t (logic [255:0]), tag_t (logic [26:0]), word_idx_t (logic [2:0])
  - state_t enum {IDLE, WRITEBACK, FILL, WTHRU}
  - constants LINE_BYTES=32, OFFSET_BITS=5
- Sub-module `line_buf_word_merge` (combinational): inputs line, word index, byte enable, wdata; output merged line. Shared by write-hit and write-through paths.

## Test plan
- Reset then read 0x0000_0040 with zero-wait memory holding 0x11…: FILL at 0x40 for 1 cycle, mem_resp in cycle 2, word 0 returned.
- Read hit to 0x44 right after: mem_resp in the same cycle, pmem strobes stay 0.
- Write 0xDEADBEEF, byte_enable 4'b0101, to 0x48, then read 0x48:
  - Only bytes 0 and 2 change.
  - Write-back build: no pmem traffic.
  - Write-through build: one pmem_write to 0x40 with the merged line.
- Write-back build, dirty line at 0x40, read 0x1000_0000:
  - pmem_write to 0x40 with the modified line, then pmem_read to 0x1000_0000, then mem_resp.
- Responder delayed 3 cycles: strobe and address held for exactly 3 cycles; no mem_resp before the fill completes.
- rst asserted mid-FILL: strobes drop to 0 asynchronously, valid=0; the next read to the same address refetches.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared types and constants for the single-line buffer / line-memory initiator.
package line_buf_pkg;

    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = 5;

    typedef logic [255:0] line_t;
    typedef logic [26:0]  tag_t;
    typedef logic [2:0]   word_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL,
        WTHRU
    } state_t;

endpackage

// File: rtl/line_buffer_initiator_if.sv
// CPU word port and physical line port of the line buffer, grouped as one bundle.
interface line_buffer_initiator_if;
    import line_buf_pkg::*;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    line_t       pmem_wdata;
    logic        pmem_resp;
    line_t       pmem_rdata;

    modport master (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );

endinterface

// File: rtl/line_buffer_initiator_word_merge.sv
// Combinational byte-masked merge of one 32-bit word into a 256-bit line.
module line_buf_word_merge
    import line_buf_pkg::*;
(
    input  line_t       line,
    input  word_idx_t   idx,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] wdata,
    output line_t       merged
);

    logic [7:0] pos;

    always_comb begin
        merged = line;
        pos    = '0;
        for (int b = 0; b < 4; b++) begin
            pos = {idx, 2'(b), 3'b000};
            if (byte_enable[b]) begin
                merged[pos +: 8] = wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/line_buffer_initiator.sv
// Single-line buffer serving CPU word accesses and issuing line fills/write-backs.
// Optional build macro LINE_BUF_WRITE_THROUGH_EN selects write-through instead of write-back.
module line_buffer_initiator
    import line_buf_pkg::*;
(
    input logic                     clk,
    input logic                     rst,
    line_buffer_initiator_if.master bus
);

    state_t    state;
    state_t    state_nxt;
    line_t     line;
    line_t     merged;
    tag_t      tag;
    logic      valid;
`ifndef LINE_BUF_WRITE_THROUGH_EN
    logic      dirty;
`endif

    tag_t      req_tag;
    word_idx_t idx;
    logic      req;
    logic      wr;
    logic      hit;
    logic      unused_addr;

    assign req_tag     = bus.mem_address[31:OFFSET_BITS];
    assign idx         = bus.mem_address[4:2];
    assign unused_addr = ^bus.mem_address[1:0];
    // A simultaneous read and write strobe is served as a write.
    assign wr          = bus.mem_write;
    assign req         = bus.mem_read | bus.mem_write;
    assign hit         = valid && (tag == req_tag);

    line_buf_word_merge u_merge (
        .line        (line),
        .idx         (idx),
        .byte_enable (bus.mem_byte_enable),
        .wdata       (bus.mem_wdata),
        .merged      (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req && !hit) begin
`ifdef LINE_BUF_WRITE_THROUGH_EN
                    state_nxt = FILL;
`else
                    state_nxt = dirty ? WRITEBACK : FILL;
`endif
                end
`ifdef LINE_BUF_WRITE_THROUGH_EN
                else if (req && wr) begin
                    state_nxt = WTHRU;
                end
`endif
            end
`ifndef LINE_BUF_WRITE_THROUGH_EN
            WRITEBACK: if (bus.pmem_resp) state_nxt = FILL;
`endif
            FILL:      if (bus.pmem_resp) state_nxt = IDLE;
`ifdef LINE_BUF_WRITE_THROUGH_EN
            WTHRU:     if (bus.pmem_resp) state_nxt = IDLE;
`endif
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = line[{idx, 5'b00000} +: 32];
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        case (state)
            IDLE: begin
`ifdef LINE_BUF_WRITE_THROUGH_EN
                // Write hits complete later, once the line has gone out in WTHRU.
                bus.mem_resp = req && hit && !wr && !rst;
`else
                bus.mem_resp = req && hit && !rst;
`endif
            end
`ifndef LINE_BUF_WRITE_THROUGH_EN
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag, 5'b00000};
                bus.pmem_wdata   = line;
            end
`endif
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, 5'b00000};
            end
`ifdef LINE_BUF_WRITE_THROUGH_EN
            WTHRU: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag, 5'b00000};
                bus.pmem_wdata   = line;
                bus.mem_resp     = bus.pmem_resp && !rst;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line  <= '0;
            tag   <= '0;
            valid <= 1'b0;
`ifndef LINE_BUF_WRITE_THROUGH_EN
            dirty <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit && wr) begin
                        line  <= merged;
`ifndef LINE_BUF_WRITE_THROUGH_EN
                        dirty <= 1'b1;
`endif
                    end
                end
`ifndef LINE_BUF_WRITE_THROUGH_EN
                WRITEBACK: begin
                    if (bus.pmem_resp) dirty <= 1'b0;
                end
`endif
                FILL: begin
                    if (bus.pmem_resp) begin
                        line  <= bus.pmem_rdata;
                        tag   <= req_tag;
                        valid <= 1'b1;
`ifndef LINE_BUF_WRITE_THROUGH_EN
                        dirty <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_initiator.sv
// Randomized bench for line_buffer_initiator with a transaction-level cache/memory model.
module tb_line_buffer_initiator;
    import line_buf_pkg::*;

    typedef struct {
        bit          w;
        logic [31:0] a;
        line_t       d;
    } op_t;

    logic clk;
    logic rst;
    line_buffer_initiator_if bus();

    line_buffer_initiator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    line_t phys_mem [logic [26:0]];
    line_t ref_mem  [logic [26:0]];
    op_t   obs_q [$];
    op_t   exp_q [$];
    int    resp_lat   = 1;
    int    strobe_cnt = 0;

    bit    m_valid;
    bit    m_dirty;
    tag_t  m_tag;
    line_t m_line;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    logic [31:0] last_rdata;
    int          last_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic line_t init_line(input tag_t t);
        line_t l;
        for (int w = 0; w < 8; w++) begin
            l[32*w +: 32] = (32'h1111_1111 * (w + 1)) ^ {t[15:0], 16'h0000};
        end
        return l;
    endfunction

    function automatic line_t phys_get(input tag_t t);
        if (phys_mem.exists(t)) return phys_mem[t];
        return init_line(t);
    endfunction

    function automatic line_t ref_get(input tag_t t);
        if (ref_mem.exists(t)) return ref_mem[t];
        return init_line(t);
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_dirty = 0;
        m_tag   = '0;
        m_line  = '0;
    endtask

    // Predicts the line traffic, returned word and response cycle of one CPU access.
    task automatic model_access(input bit wr, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input int lat);
        tag_t t;
        int   w;
        bit   miss;
        op_t  op;
        exp_q.delete();
        t    = a[31:5];
        w    = int'(a[4:2]);
        miss = !(m_valid && m_tag == t);
        if (miss) begin
`ifndef LINE_BUF_WRITE_THROUGH_EN
            if (m_valid && m_dirty) begin
                op.w = 1; op.a = {m_tag, 5'b0}; op.d = m_line;
                exp_q.push_back(op);
                ref_mem[m_tag] = m_line;
            end
`endif
            op.w = 0; op.a = {t, 5'b0}; op.d = '0;
            exp_q.push_back(op);
            m_line  = ref_get(t);
            m_tag   = t;
            m_valid = 1;
            m_dirty = 0;
        end
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_line[32*w + 8*b +: 8] = wd[8*b +: 8];
            end
`ifdef LINE_BUF_WRITE_THROUGH_EN
            op.w = 1; op.a = {t, 5'b0}; op.d = m_line;
            exp_q.push_back(op);
            ref_mem[t] = m_line;
`else
            m_dirty = 1;
`endif
        end
        exp_rdata = m_line[32*w +: 32];
        exp_cyc   = exp_q.size() * lat + (miss ? 1 : 0);
    endtask

    // Line-memory responder: completes each request after resp_lat strobe cycles.
    initial begin : responder
        int  cnt;
        op_t cur;
        cnt = 0;
        cur.w = 0; cur.a = '0; cur.d = '0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                cnt = 0;
                bus.pmem_resp = 1'b0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                chk("pmem_excl", 256'(bus.pmem_read & bus.pmem_write), 256'(0));
                if (cnt == 0) begin
                    cur.w = bus.pmem_write;
                    cur.a = bus.pmem_address;
                end else begin
                    chk("pmem_addr_hold", 256'(bus.pmem_address), 256'(cur.a));
                end
                strobe_cnt++;
                if (cnt == resp_lat - 1) begin
                    if (cur.w) begin
                        cur.d = bus.pmem_wdata;
                        phys_mem[cur.a[31:5]] = bus.pmem_wdata;
                    end else begin
                        cur.d = '0;
                        bus.pmem_rdata = phys_get(cur.a[31:5]);
                    end
                    obs_q.push_back(cur);
                    bus.pmem_resp = 1'b1;
                    cnt = 0;
                end else begin
                    bus.pmem_resp = 1'b0;
                    cnt++;
                end
            end else begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input int lat);
        int cyc;
        bit done;
        model_access(wr, a, be, wd, lat);
        resp_lat = lat;
        obs_q.delete();
        strobe_cnt = 0;
        @(posedge clk);
        #1;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = a;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        cyc  = 0;
        done = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                done = 1;
                last_rdata = bus.mem_rdata;
                break;
            end
            cyc++;
        end
        last_cyc = cyc;
        chk("resp_seen", 256'(done), 256'(1));
        chk("resp_cycle", 256'(cyc), 256'(exp_cyc));
        if (!wr) chk("rdata", 256'(last_rdata), 256'(exp_rdata));
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        chk("pmem_ops", 256'(obs_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk("op_kind", 256'(obs_q[i].w), 256'(exp_q[i].w));
            chk("op_addr", 256'(obs_q[i].a), 256'(exp_q[i].a));
            if (exp_q[i].w) chk("op_wdata", obs_q[i].d, exp_q[i].d);
        end
        chk("strobe_cycles", 256'(strobe_cnt), 256'(exp_q.size() * lat));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [26:0] tags [4];
        int          r;
        logic [31:0] a;
        tags[0] = 27'h0000002;
        tags[1] = 27'h0000003;
        tags[2] = 27'h0800000;
        tags[3] = 27'h1000000;

        rst = 1'b1;
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_byte_enable = '0;
        bus.mem_address = '0; bus.mem_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        chk("rst_mem_resp", 256'(bus.mem_resp), 256'(0));
        chk("rst_mem_rdata", 256'(bus.mem_rdata), 256'(0));
        chk("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
        chk("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
        chk("rst_pmem_addr", 256'(bus.pmem_address), 256'(0));
        chk("rst_pmem_wdata", bus.pmem_wdata, 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        access(1, 0, 32'h0000_0040, 4'h0, 32'h0, 1);
        chk("first_fill_word0", 256'(last_rdata), 256'(32'h1113_1111));
        chk("first_fill_cycle", 256'(last_cyc), 256'(2));
        access(1, 0, 32'h0000_0044, 4'h0, 32'h0, 1);
        chk("hit_cycle", 256'(last_cyc), 256'(0));
        access(0, 1, 32'h0000_0048, 4'b0101, 32'hDEAD_BEEF, 1);
        access(1, 0, 32'h0000_0048, 4'h0, 32'h0, 1);
        chk("merged_word", 256'(last_rdata), 256'(32'h33AD_33EF));
        access(1, 0, 32'h1000_0000, 4'h0, 32'h0, 1);
        access(1, 0, 32'h2000_0000, 4'h0, 32'h0, 3);
        chk("slow_fill_cycle", 256'(last_cyc), 256'(4));

        // Reset in the middle of a three-cycle fill, then the same read must refetch.
        resp_lat = 3;
        @(posedge clk);
        #1;
        bus.mem_read    = 1'b1;
        bus.mem_address = 32'h3000_0040;
        @(posedge clk);
        #4;
        chk("midfill_strobe", 256'(bus.pmem_read), 256'(1));
        rst = 1'b1;
        #1;
        chk("midfill_rst_read", 256'(bus.pmem_read), 256'(0));
        chk("midfill_rst_write", 256'(bus.pmem_write), 256'(0));
        chk("midfill_rst_addr", 256'(bus.pmem_address), 256'(0));
        chk("midfill_rst_resp", 256'(bus.mem_resp), 256'(0));
        chk("midfill_rst_rdata", 256'(bus.mem_rdata), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_read = 1'b0;
        model_reset();
        access(1, 0, 32'h3000_0040, 4'h0, 32'h0, 2);
        chk("refetch_cycle", 256'(last_cyc), 256'(3));

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 3));
            a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(r != 2, r >= 2, a, 4'($urandom_range(0, 15)), $urandom,
                   int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
